// File: rtl/zapper_pkg.sv
// zapper_pkg: shared types and default parameter values for the light-gun
// front end (zapper_if and zapper_debounce).
package zapper_pkg;

  // Shot sequence states, in the order they are visited after a trigger press.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    DARK    = 3'd2,
    LIT     = 3'd3,
    RELEASE = 3'd4
  } zapper_state_t;

  // 10 ms of stable trigger at a 25 MHz pixel clock.
  localparam int unsigned DEF_DEBOUNCE_CYCLES  = 32'd250000;
  localparam int unsigned DEF_LIGHT_MIN_CYCLES = 32'd64;
  localparam int unsigned DEF_SYNC_STAGES      = 32'd2;

endpackage

// File: rtl/zapper_debounce.sv
// zapper_debounce: SYNC_STAGES-deep synchroniser followed by a debounce
// counter. The output level only follows the synchronised input after it has
// differed from the current level for DEBOUNCE_CYCLES consecutive cycles.
module zapper_debounce
  import zapper_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic screen_reset,
  input  logic din_raw,
  output logic dout
);

  // One spare bit so the counter can never wrap before it clears.
  localparam int unsigned         CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   din_s;

  assign din_s = sync_q[SYNC_STAGES-1];
  assign dout  = level_q;

  // Shift the synchroniser and decide whether the debounced level may change.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], din_raw};
    level_d = level_q;
    cnt_d   = '0;
    if (din_s == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      level_d = din_s;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Synchroniser, counter and debounced level registers.
  always_ff @(posedge clk or posedge screen_reset) begin
    if (screen_reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/zapper_if.sv
// zapper_if: light-gun front end. Debounces the trigger, walks the
// ARMED -> DARK -> LIT -> RELEASE frame sequence after each shot and raises
// detect when enough light is seen during the lit frame.
// Optional build macro ZAPPER_DARK_CHECK_EN: light seen during the dark frame
// vetoes detect for that shot (ambient / aim-at-lamp rejection).
module zapper_if
  import zapper_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LIGHT_MIN_CYCLES = DEF_LIGHT_MIN_CYCLES,
  parameter int unsigned SYNC_STAGES      = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic screen_reset,
  input  logic frame_start,
  input  logic trig_raw,
  input  logic light_raw,
  output logic trigger,
  output logic detect,
  output logic busy
);

  localparam int unsigned       LCNT_W   = $clog2(LIGHT_MIN_CYCLES + 1);
  localparam logic [LCNT_W-1:0] LCNT_MAX = LCNT_W'(LIGHT_MIN_CYCLES);

  logic                   trigger_db;
  logic                   trig_prev_q, trig_prev_d;
  logic                   shot;
  logic [SYNC_STAGES-1:0] light_sync_q, light_sync_d;
  logic                   light_s;
  zapper_state_t          state_q, state_d;
  logic [LCNT_W-1:0]      light_cnt_q, light_cnt_d;
  logic                   light_full;
  logic                   lit_flag_q, lit_flag_d;
  logic                   detect_q, detect_d;
  logic                   busy_q, busy_d;
  logic                   reject;
  logic                   arming;

  zapper_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_trig_db (
    .clk         (clk),
    .screen_reset(screen_reset),
    .din_raw     (trig_raw),
    .dout        (trigger_db)
  );

  assign trigger = trigger_db;
  assign detect  = detect_q;
  assign busy    = busy_q;
  assign light_s = light_sync_q[SYNC_STAGES-1];
  assign shot    = trigger_db & ~trig_prev_q;
  assign arming  = (state_q == IDLE) && (state_d == ARMED);

  // Next-state logic; frame_start is ignored in IDLE and RELEASE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (shot)        state_d = ARMED;   else state_d = state_q;
      ARMED:   if (frame_start) state_d = DARK;    else state_d = state_q;
      DARK:    if (frame_start) state_d = LIT;     else state_d = state_q;
      LIT:     if (frame_start) state_d = RELEASE; else state_d = state_q;
      RELEASE: if (!trigger_db) state_d = IDLE;    else state_d = state_q;
      default: state_d = IDLE;
    endcase
  end

  // Light run-length counter and lit flag; the counter restarts on every
  // state change so a run never spans two frames.
  always_comb begin
    trig_prev_d  = trigger_db;
    light_sync_d = {light_sync_q[SYNC_STAGES-2:0], light_raw};
    light_cnt_d  = '0;
    if (state_d != state_q) begin
      light_cnt_d = '0;
    end else if (((state_q == DARK) || (state_q == LIT)) && light_s) begin
      if (light_cnt_q == LCNT_MAX) begin
        light_cnt_d = light_cnt_q;
      end else begin
        light_cnt_d = light_cnt_q + LCNT_W'(1);
      end
    end else begin
      light_cnt_d = '0;
    end
    light_full = (light_cnt_d == LCNT_MAX);
    if (arming) begin
      lit_flag_d = 1'b0;
    end else if (light_full && (state_q == LIT)) begin
      lit_flag_d = 1'b1;
    end else begin
      lit_flag_d = lit_flag_q;
    end
  end

`ifdef ZAPPER_DARK_CHECK_EN
  logic dark_flag_q, dark_flag_d;

  assign reject = dark_flag_q;

  // Sticky record of light seen during the dark frame of the current shot.
  always_comb begin
    if (arming) begin
      dark_flag_d = 1'b0;
    end else if (light_full && (state_q == DARK)) begin
      dark_flag_d = 1'b1;
    end else begin
      dark_flag_d = dark_flag_q;
    end
  end

  // Dark flag register.
  always_ff @(posedge clk or posedge screen_reset) begin
    if (screen_reset) begin
      dark_flag_q <= 1'b0;
    end else begin
      dark_flag_q <= dark_flag_d;
    end
  end
`else
  assign reject = 1'b0;
`endif

  // Registered outputs; detect uses the next state so it drops on the
  // frame_start edge that closes the lit frame.
  always_comb begin
    detect_d = lit_flag_q & (state_d == LIT) & ~reject;
    busy_d   = (state_d != IDLE);
  end

  // State, counter, flag and output registers.
  always_ff @(posedge clk or posedge screen_reset) begin
    if (screen_reset) begin
      trig_prev_q  <= 1'b0;
      light_sync_q <= '0;
      state_q      <= IDLE;
      light_cnt_q  <= '0;
      lit_flag_q   <= 1'b0;
      detect_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      trig_prev_q  <= trig_prev_d;
      light_sync_q <= light_sync_d;
      state_q      <= state_d;
      light_cnt_q  <= light_cnt_d;
      lit_flag_q   <= lit_flag_d;
      detect_q     <= detect_d;
      busy_q       <= busy_d;
    end
  end

endmodule

// File: tb/tb_zapper_if.sv
// tb_zapper_if: directed test of zapper_if with DEBOUNCE_CYCLES=8,
// LIGHT_MIN_CYCLES=4, SYNC_STAGES=2 and a frame_start pulse every 100 clk.
module tb_zapper_if;

  logic clk = 1'b0;
  logic screen_reset, frame_start, trig_raw, light_raw;
  logic trigger, detect, busy;
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cyc          = 0;

  always #5 clk = ~clk;

  zapper_if #(
    .DEBOUNCE_CYCLES (8),
    .LIGHT_MIN_CYCLES(4),
    .SYNC_STAGES     (2)
  ) dut (
    .clk         (clk),
    .screen_reset(screen_reset),
    .frame_start (frame_start),
    .trig_raw    (trig_raw),
    .light_raw   (light_raw),
    .trigger     (trigger),
    .detect      (detect),
    .busy        (busy)
  );

  // One clock: sample point is 1 time unit after the rising edge; the frame
  // generator lives here so frame_start stays on the bench's own schedule.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    frame_start = ((cyc % 100) == 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Return with frame_start pending for the next edge.
  task automatic wait_frame();
    for (int i = 0; i < 101 && !frame_start; i++) tick();
  endtask

  task automatic sync_frame();
    wait_frame();
    tick();
  endtask

  task automatic apply_reset();
    screen_reset = 1'b1;
    trig_raw     = 1'b0;
    light_raw    = 1'b0;
    ticks(3);
    screen_reset = 1'b0;
    tick();
  endtask

  // Press: trigger rises after 10 clk, the shot moves the FSM on clk 11.
  task automatic press();
    trig_raw = 1'b1;
    ticks(11);
  endtask

  task automatic test_reset();
    screen_reset = 1'b1;
    #1;
    tests_run++;
    if (trigger !== 1'b0 || detect !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: trigger=%b detect=%b busy=%b expected 000", trigger, detect, busy);
    end
    ticks(3);
    screen_reset = 1'b0;
    ticks(150);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_ignores_frame: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_debounce();
    int early;
    apply_reset();
    sync_frame();
    early = 0;
    for (int i = 0; i < 10; i++) begin
      trig_raw = ~trig_raw;
      for (int j = 0; j < 3; j++) begin
        tick();
        if (trigger !== 1'b0) early++;
      end
    end
    tests_run++;
    if (early != 0) begin
      tests_failed++;
      $display("FAIL debounce_bounce: trigger high on %0d cycles, expected 0", early);
    end
    trig_raw = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      tests_run++;
      if (trigger !== (k == 10)) begin
        tests_failed++;
        $display("FAIL debounce_latency: clk %0d trigger=%b expected %b", k, trigger, (k == 10));
      end
    end
    tick();
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL shot_accept: busy=%b expected 1", busy);
    end
  endtask

  task automatic test_hit();
    int drops;
    apply_reset();
    sync_frame();
    press();
    wait_frame(); tick();            // DARK
    wait_frame(); tick();            // LIT
    light_raw = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      tests_run++;
      if (detect !== (k == 7)) begin
        tests_failed++;
        $display("FAIL hit_rise: clk %0d detect=%b expected %b", k, detect, (k == 7));
      end
    end
    ticks(3);
    light_raw = 1'b0;
    drops = 0;
    for (int i = 0; i < 101 && !frame_start; i++) begin
      tick();
      if (detect !== 1'b1) drops++;
    end
    tests_run++;
    if (drops != 0 || detect !== 1'b1) begin
      tests_failed++;
      $display("FAIL hit_hold: detect=%b drops=%0d expected 1 and 0", detect, drops);
    end
    tick();
    tests_run++;
    if (detect !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL hit_fall: detect=%b busy=%b expected 0 1", detect, busy);
    end
    trig_raw = 1'b0;
    ticks(10);
    tests_run++;
    if (busy !== 1'b1 || trigger !== 1'b0) begin
      tests_failed++;
      $display("FAIL hit_release_wait: busy=%b trigger=%b expected 1 0", busy, trigger);
    end
    tick();
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL hit_idle: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_miss();
    int seen;
    apply_reset();
    sync_frame();
    press();
    wait_frame(); tick();
    wait_frame(); tick();
    seen = 0;
    for (int p = 0; p < 5; p++) begin
      light_raw = 1'b1;
      for (int j = 0; j < 3; j++) begin tick(); if (detect !== 1'b0) seen++; end
      light_raw = 1'b0;
      for (int j = 0; j < 3; j++) begin tick(); if (detect !== 1'b0) seen++; end
    end
    for (int i = 0; i < 101 && !frame_start; i++) begin
      tick();
      if (detect !== 1'b0) seen++;
    end
    tests_run++;
    if (seen != 0) begin
      tests_failed++;
      $display("FAIL miss_no_detect: detect high on %0d cycles, expected 0", seen);
    end
    tick();
    tests_run++;
    if (busy !== 1'b1 || detect !== 1'b0) begin
      tests_failed++;
      $display("FAIL miss_release: busy=%b detect=%b expected 1 0", busy, detect);
    end
    trig_raw = 1'b0;
    ticks(11);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL miss_idle: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_dark_check();
    logic exp_det;
`ifdef ZAPPER_DARK_CHECK_EN
    exp_det = 1'b0;
`else
    exp_det = 1'b1;
`endif
    apply_reset();
    sync_frame();
    press();
    wait_frame(); tick();            // DARK
    light_raw = 1'b1;
    ticks(20);
    light_raw = 1'b0;
    wait_frame(); tick();            // LIT
    light_raw = 1'b1;
    ticks(7);
    tests_run++;
    if (detect !== exp_det) begin
      tests_failed++;
      $display("FAIL dark_check_rise: detect=%b expected %b", detect, exp_det);
    end
    ticks(3);
    light_raw = 1'b0;
    wait_frame();
    tests_run++;
    if (detect !== exp_det) begin
      tests_failed++;
      $display("FAIL dark_check_hold: detect=%b expected %b", detect, exp_det);
    end
    tick();
    trig_raw = 1'b0;
    ticks(11);
    tests_run++;
    if (busy !== 1'b0 || detect !== 1'b0) begin
      tests_failed++;
      $display("FAIL dark_check_idle: busy=%b detect=%b expected 0 0", busy, detect);
    end
  endtask

  task automatic test_held_trigger();
    int drops;
    apply_reset();
    sync_frame();
    press();
    drops = 0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (busy !== 1'b1) drops++;
    end
    tests_run++;
    if (drops != 0) begin
      tests_failed++;
      $display("FAIL held_busy: busy low on %0d cycles, expected 0", drops);
    end
    trig_raw = 1'b0;
    ticks(10);
    tests_run++;
    if (busy !== 1'b1 || trigger !== 1'b0) begin
      tests_failed++;
      $display("FAIL held_release_edge: busy=%b trigger=%b expected 1 0", busy, trigger);
    end
    tick();
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL held_idle: busy=%b expected 0", busy);
    end
    drops = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (busy !== 1'b0) drops++;
    end
    tests_run++;
    if (drops != 0) begin
      tests_failed++;
      $display("FAIL held_single_seq: busy high on %0d cycles, expected 0", drops);
    end
  endtask

  task automatic test_reset_mid_lit();
    apply_reset();
    sync_frame();
    press();
    wait_frame(); tick();
    wait_frame(); tick();
    light_raw = 1'b1;
    ticks(8);
    tests_run++;
    if (detect !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_pre_detect: detect=%b expected 1", detect);
    end
    #2;
    screen_reset = 1'b1;
    #1;
    tests_run++;
    if (detect !== 1'b0 || trigger !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_async: detect=%b trigger=%b busy=%b expected 000", detect, trigger, busy);
    end
    trig_raw  = 1'b0;
    light_raw = 1'b0;
    ticks(3);
    screen_reset = 1'b0;
    ticks(150);
    tests_run++;
    if (busy !== 1'b0 || detect !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_stays_idle: busy=%b detect=%b expected 0 0", busy, detect);
    end
    press();
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_new_press: busy=%b expected 1", busy);
    end
  endtask

  initial begin
    screen_reset = 1'b1;
    frame_start  = 1'b0;
    trig_raw     = 1'b0;
    light_raw    = 1'b0;
    test_reset();
    test_debounce();
    test_hit();
    test_miss();
    test_dark_check();
    test_held_trigger();
    test_reset_mid_lit();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, tests_failed=%0d", tests_failed);
    $fatal(1, "watchdog");
  end

endmodule
